// File: rtl/gerenciador_display_temporizado.sv
`default_nettype none
// ============================================================================
// Module   : gerenciador_display_temporizado
// Brief    : Single 7-segment digit manager for the elevator cabin. Shows
//            either the current floor or the occupancy. The source is chosen
//            by timed auto-alternation or by a fixed mode, and motion always
//            forces the floor. The occupancy digit blinks while the cabin is
//            over capacity.
// Revision : 1.0 - initial release
// ============================================================================
module gerenciador_display_temporizado #(
    parameter int LARG_ANDAR     = 2,
    parameter int LARG_PESSOAS   = 4,
    parameter int LIMITE_PESSOAS = 8,
    parameter int CICLOS_TROCA   = 50000000,
    parameter int CICLOS_PISCA   = 12500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LARG_ANDAR-1:0]   andar,
    input  logic [LARG_PESSOAS-1:0] pessoas,
    input  logic [1:0]              modo,
    input  logic                    em_movimento,
    output logic [6:0]              segmentos,
    output logic                    exibindo_pessoas,
    output logic                    alerta_lotacao
);

    // Counter widths and terminal values
    localparam int c_W_TROCA = (CICLOS_TROCA > 2) ? $clog2(CICLOS_TROCA) : 1;
    localparam int c_W_PISCA = (CICLOS_PISCA > 2) ? $clog2(CICLOS_PISCA) : 1;
    localparam logic [c_W_TROCA-1:0] c_FIM_TROCA = c_W_TROCA'(CICLOS_TROCA - 1);
    localparam logic [c_W_PISCA-1:0] c_FIM_PISCA = c_W_PISCA'(CICLOS_PISCA - 1);

    // Displayed value is wide enough for either source and for digit decoding
    localparam int c_LARG_MAX = (LARG_ANDAR > LARG_PESSOAS) ? LARG_ANDAR : LARG_PESSOAS;
    localparam int c_LARG_VAL = (c_LARG_MAX > 4) ? c_LARG_MAX : 4;

    localparam logic [6:0] c_SEG_APAGADO = 7'b0000000;
    localparam logic [6:0] c_SEG_ERRO    = 7'b1001111;

    logic [LARG_ANDAR-1:0]   r_andar;
    logic [LARG_PESSOAS-1:0] r_pessoas;
    logic [1:0]              r_modo;
    logic                    r_mov;

    logic                    r_sel;        // 0 = floor, 1 = occupancy
    logic                    r_auto_prev;  // previous cycle was in auto mode
    logic [c_W_TROCA-1:0]    r_cont_troca;
    logic [c_W_PISCA-1:0]    r_cont_pisca;
    logic                    r_fase_pisca; // 1 = visible half of the blink

    logic                    w_auto;
    logic                    w_alerta;
    logic                    w_sel_next;
    logic [c_W_TROCA-1:0]    w_troca_next;
    logic [c_LARG_VAL-1:0]   w_valor;
    logic [6:0]              w_seg_cod;

    assign w_auto   = !r_mov && (r_modo[0] == r_modo[1]);
    assign w_alerta = (32'(r_pessoas) > 32'(LIMITE_PESSOAS));

    // Register the raw controller inputs; every decision below uses these copies
    always_ff @(posedge clk) begin
        if (reset) begin
            r_andar   <= '0;
            r_pessoas <= '0;
            r_modo    <= 2'b00;
            r_mov     <= 1'b0;
        end else begin
            r_andar   <= andar;
            r_pessoas <= pessoas;
            r_modo    <= modo;
            r_mov     <= em_movimento;
        end
    end

    // Next source: motion, then fixed mode, then auto alternation timer
    always_comb begin
        w_sel_next   = r_sel;
        w_troca_next = r_cont_troca;
        if (r_mov || (r_modo == 2'b01)) begin
            w_sel_next   = 1'b0;
            w_troca_next = '0;
        end else if (r_modo == 2'b10) begin
            w_sel_next   = 1'b1;
            w_troca_next = '0;
        end else if (!r_auto_prev) begin
            // Freshly entered auto: this cycle does not count, so the floor
            // gets a full period before the first swap
            w_sel_next   = 1'b0;
            w_troca_next = '0;
        end else if (r_cont_troca == c_FIM_TROCA) begin
            w_sel_next   = ~r_sel;
            w_troca_next = '0;
        end else begin
            w_troca_next = r_cont_troca + 1'b1;
        end
    end

    // Source selection state and alternation timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel        <= 1'b0;
            r_auto_prev  <= 1'b0;
            r_cont_troca <= '0;
        end else begin
            r_sel        <= w_sel_next;
            r_auto_prev  <= w_auto;
            r_cont_troca <= w_troca_next;
        end
    end

    // Blink timer; parked in the visible phase whenever the alarm is off
    always_ff @(posedge clk) begin
        if (reset || !w_alerta) begin
            r_cont_pisca <= '0;
            r_fase_pisca <= 1'b1;
        end else if (r_cont_pisca == c_FIM_PISCA) begin
            r_cont_pisca <= '0;
            r_fase_pisca <= ~r_fase_pisca;
        end else begin
            r_cont_pisca <= r_cont_pisca + 1'b1;
        end
    end

    assign w_valor = w_sel_next ? c_LARG_VAL'(r_pessoas) : c_LARG_VAL'(r_andar);

    // Decimal digit decoder, anything above nine shows 'E'
    always_comb begin
        w_seg_cod = c_SEG_ERRO;
        if (w_valor <= c_LARG_VAL'(9)) begin
            case (w_valor[3:0])
                4'd0:    w_seg_cod = 7'b1111110;
                4'd1:    w_seg_cod = 7'b0110000;
                4'd2:    w_seg_cod = 7'b1101101;
                4'd3:    w_seg_cod = 7'b1111001;
                4'd4:    w_seg_cod = 7'b0110011;
                4'd5:    w_seg_cod = 7'b1011011;
                4'd6:    w_seg_cod = 7'b1011111;
                4'd7:    w_seg_cod = 7'b1110000;
                4'd8:    w_seg_cod = 7'b1111111;
                4'd9:    w_seg_cod = 7'b1111011;
                default: w_seg_cod = c_SEG_ERRO;
            endcase
        end
    end

    // Output registers; only the occupancy digit is blanked by the alarm
    always_ff @(posedge clk) begin
        if (reset) begin
            segmentos        <= c_SEG_APAGADO;
            exibindo_pessoas <= 1'b0;
            alerta_lotacao   <= 1'b0;
        end else begin
            segmentos        <= (w_sel_next && w_alerta && !r_fase_pisca) ? c_SEG_APAGADO
                                                                          : w_seg_cod;
            exibindo_pessoas <= w_sel_next;
            alerta_lotacao   <= w_alerta;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gerenciador_display_temporizado.sv
`default_nettype none
// ============================================================================
// Module   : tb_gerenciador_display_temporizado
// Brief    : Directed self-checking bench. Expected per-cycle outputs are
//            queued when stimulus is applied and compared on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gerenciador_display_temporizado;

    localparam logic [6:0] c_BLANK = 7'b0000000;
    localparam logic [6:0] c_D0    = 7'b1111110;
    localparam logic [6:0] c_D2    = 7'b1101101;
    localparam logic [6:0] c_D3    = 7'b1111001;
    localparam logic [6:0] c_D7    = 7'b1110000;
    localparam logic [6:0] c_D8    = 7'b1111111;
    localparam logic [6:0] c_D9    = 7'b1111011;
    localparam logic [6:0] c_E     = 7'b1001111;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] andar;
    logic [3:0] pessoas;
    logic [1:0] modo;
    logic       em_movimento;
    logic [6:0] segmentos;
    logic       exibindo_pessoas;
    logic       alerta_lotacao;

    typedef struct packed {
        logic       pular;
        logic [6:0] seg;
        logic       exib;
        logic       alerta;
    } esperado_t;

    esperado_t fila[$];
    int        n_total  = 0;
    int        n_passou = 0;
    int        n_ciclo  = 0;

    gerenciador_display_temporizado #(
        .LARG_ANDAR     (2),
        .LARG_PESSOAS   (4),
        .LIMITE_PESSOAS (8),
        .CICLOS_TROCA   (4),
        .CICLOS_PISCA   (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .andar            (andar),
        .pessoas          (pessoas),
        .modo             (modo),
        .em_movimento     (em_movimento),
        .segmentos        (segmentos),
        .exibindo_pessoas (exibindo_pessoas),
        .alerta_lotacao   (alerta_lotacao)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", fila.size());
        $fatal(1, "watchdog expired");
    end

    task automatic esperar(input logic [6:0] seg, input logic exib, input logic alerta, input int n);
        for (int i = 0; i < n; i++) fila.push_back('{1'b0, seg, exib, alerta});
    endtask

    task automatic ignorar(input int n);
        for (int i = 0; i < n; i++) fila.push_back('{1'b1, 7'b0, 1'b0, 1'b0});
    endtask

    // Consume queued expectations, one per falling edge
    task automatic drenar(input string tag);
        esperado_t e;
        while (fila.size() > 0) begin
            @(negedge clk);
            n_ciclo++;
            e = fila.pop_front();
            if (!e.pular) begin
                n_total++;
                assert (segmentos === e.seg) n_passou++;
                else $error("FAIL %s_seg cyc%0d: observed %b expected %b", tag, n_ciclo, segmentos, e.seg);
                n_total++;
                assert (exibindo_pessoas === e.exib) n_passou++;
                else $error("FAIL %s_exib cyc%0d: observed %b expected %b", tag, n_ciclo, exibindo_pessoas, e.exib);
                n_total++;
                assert (alerta_lotacao === e.alerta) n_passou++;
                else $error("FAIL %s_alerta cyc%0d: observed %b expected %b", tag, n_ciclo, alerta_lotacao, e.alerta);
            end
        end
    endtask

    initial begin
        // Reset with live-looking inputs: outputs stay blank
        reset = 1'b1; andar = 2'd3; pessoas = 4'd5; modo = 2'b00; em_movimento = 1'b0;
        esperar(c_BLANK, 1'b0, 1'b0, 2);
        drenar("reset");

        // Release into fixed floor mode: floor 3 after two cycles
        reset = 1'b0; modo = 2'b01;
        ignorar(1);
        esperar(c_D3, 1'b0, 1'b0, 2);
        drenar("fixo_andar");

        // Auto alternation: floor 2 for four cycles, then occupancy 7
        modo = 2'b00; andar = 2'd2; pessoas = 4'd7;
        esperar(c_D3, 1'b0, 1'b0, 1);
        esperar(c_D2, 1'b0, 1'b0, 4);
        esperar(c_D7, 1'b1, 1'b0, 2);
        drenar("auto");

        // Motion while the occupancy digit is shown
        em_movimento = 1'b1;
        esperar(c_D7, 1'b1, 1'b0, 1);
        esperar(c_D2, 1'b0, 1'b0, 2);
        drenar("movimento");

        // Release motion: floor gets a full period before occupancy
        em_movimento = 1'b0;
        esperar(c_D2, 1'b0, 1'b0, 1);
        esperar(c_D2, 1'b0, 1'b0, 4);
        esperar(c_D7, 1'b1, 1'b0, 2);
        drenar("pos_movimento");

        // Over capacity in fixed occupancy mode: blink starts visible
        modo = 2'b10; pessoas = 4'd9;
        esperar(c_D7, 1'b1, 1'b0, 1);
        esperar(c_D9, 1'b1, 1'b1, 2);
        esperar(c_BLANK, 1'b1, 1'b1, 2);
        esperar(c_D9, 1'b1, 1'b1, 2);
        esperar(c_BLANK, 1'b1, 1'b1, 1);
        drenar("alarme");

        // Exactly at the limit: alarm clears, steady 8
        pessoas = 4'd8;
        esperar(c_BLANK, 1'b1, 1'b1, 1);
        esperar(c_D8, 1'b1, 1'b0, 2);
        drenar("limite");

        // Out-of-range occupancy: blinking 'E'
        pessoas = 4'd12;
        esperar(c_D8, 1'b1, 1'b0, 1);
        esperar(c_E, 1'b1, 1'b1, 2);
        esperar(c_BLANK, 1'b1, 1'b1, 2);
        esperar(c_E, 1'b1, 1'b1, 1);
        drenar("erro");

        // Floor display is never blanked by the alarm
        modo = 2'b01; andar = 2'd3;
        esperar(c_E, 1'b1, 1'b1, 1);
        esperar(c_D3, 1'b0, 1'b1, 3);
        drenar("andar_alarme");

        // Back to occupancy, landing in the blank phase
        modo = 2'b10;
        esperar(c_D3, 1'b0, 1'b1, 1);
        esperar(c_BLANK, 1'b1, 1'b1, 1);
        drenar("pre_reset");

        // Reset during the blank phase, then release with unchanged inputs
        reset = 1'b1;
        esperar(c_BLANK, 1'b0, 1'b0, 1);
        drenar("reset_meio");
        reset = 1'b0;
        esperar(c_D0, 1'b0, 1'b0, 1);
        esperar(c_E, 1'b1, 1'b1, 2);
        esperar(c_BLANK, 1'b1, 1'b1, 1);
        drenar("pos_reset");

        $display("%0d/%0d checks passed", n_passou, n_total);
        $finish;
    end

endmodule
`default_nettype wire
